// File: rtl/uart_receiver.sv
// ============================================================================
// uart_receiver : oversampling UART receive front end, 8-N/E/O-1, LSB first
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_receiver #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  output logic [DATA_WIDTH-1:0]     parallel_data,
  output logic                      parallel_data_valid,
  output logic                      parity_error,
  output logic                      stop_error
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_WIDTH-1:0] c_ps8  = PRESCALE_WIDTH'(8);
  localparam logic [PRESCALE_WIDTH-1:0] c_ps16 = PRESCALE_WIDTH'(16);
  localparam logic [PRESCALE_WIDTH-1:0] c_ps32 = PRESCALE_WIDTH'(32);
  localparam logic [PRESCALE_WIDTH-1:0] c_one  = PRESCALE_WIDTH'(1);
  localparam logic [BCW-1:0]            c_last_bit = BCW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                      state_q, state_d;
  logic [PRESCALE_WIDTH-1:0]   edge_cnt_q, edge_cnt_d;
  logic [BCW-1:0]              bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_WIDTH-1:0]   pre_q, pre_d;
  logic                        par_en_q, par_en_d;
  logic                        par_type_q, par_type_d;
  logic [2:0]                  samp_q, samp_d;
  logic                        bit_val_q, bit_val_d;
  logic [DATA_WIDTH-1:0]       shift_q, shift_d;
  logic                        par_bit_q, par_bit_d;
  logic [DATA_WIDTH-1:0]       data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        perr_q, perr_d;
  logic                        serr_q, serr_d;

  logic [PRESCALE_WIDTH-1:0]   half_cnt;
  logic                        bit_end;
  logic                        start_det;
  logic                        perr_calc;
  logic                        serr_calc;

  assign half_cnt  = pre_q >> 1;
  assign bit_end   = (edge_cnt_q == (pre_q - c_one));
  assign perr_calc = par_en_q & (((^shift_q) ^ par_bit_q) != par_type_q);
  assign serr_calc = ~bit_val_q;

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    pre_d      = pre_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    samp_d     = samp_q;
    bit_val_d  = bit_val_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    serr_d     = 1'b0;
    start_det  = 1'b0;

    if (state_q != IDLE) begin
      edge_cnt_d = bit_end ? '0 : edge_cnt_q + c_one;
    end

    // Three mid-bit samples, majority vote registered one cycle later
    if (edge_cnt_q == (half_cnt - c_one)) samp_d[0] = rx_in;
    if (edge_cnt_q == half_cnt)           samp_d[1] = rx_in;
    if (edge_cnt_q == (half_cnt + c_one)) samp_d[2] = rx_in;
    if (edge_cnt_q == (half_cnt + PRESCALE_WIDTH'(2))) begin
      bit_val_d = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                  (samp_q[1] & samp_q[2]);
    end

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        start_det  = ~rx_in;
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = bit_val_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d[bit_cnt_q] = bit_val_q;
          if (bit_cnt_q == c_last_bit) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_bit_d = bit_val_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!perr_calc && !serr_calc) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            perr_d = perr_calc;
            serr_d = serr_calc;
          end
          state_d = IDLE;
          // The final stop cycle doubles as the first idle check so a frame
          // train with no gap between frames keeps its exact period.
          start_det = ~rx_in;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_det) begin
      state_d    = START;
      edge_cnt_d = '0;
      par_en_d   = parity_enable;
      par_type_d = parity_type;
      pre_d      = ((prescale == c_ps16) || (prescale == c_ps32)) ? prescale : c_ps8;
    end

    if (!enable) begin
      state_d    = IDLE;
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
      data_d     = data_q;
      valid_d    = 1'b0;
      perr_d     = 1'b0;
      serr_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      pre_q      <= c_ps8;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      samp_q     <= '0;
      bit_val_q  <= 1'b0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      pre_q      <= pre_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      samp_q     <= samp_d;
      bit_val_q  <= bit_val_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
    end
  end

  assign parallel_data       = data_q;
  assign parallel_data_valid = valid_q;
  assign parity_error        = perr_q;
  assign stop_error          = serr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// tb_uart_receiver : directed self-checking bench for uart_receiver
// Revision         : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_receiver;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       rx_in;
  logic [5:0] prescale;
  logic       parity_enable;
  logic       parity_type;
  logic [7:0] parallel_data;
  logic       parallel_data_valid;
  logic       parity_error;
  logic       stop_error;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int n_valid = 0, n_perr = 0, n_serr = 0;
  int last_valid_cyc = 0, prev_valid_cyc = 0;
  int last_perr_cyc = 0, last_serr_cyc = 0;
  logic [7:0] last_valid_data = '0, prev_valid_data = '0;
  int base_v, base_pe, base_se;
  int st, st1, st2;

  uart_receiver #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .enable              (enable),
    .rx_in               (rx_in),
    .prescale            (prescale),
    .parity_enable       (parity_enable),
    .parity_type         (parity_type),
    .parallel_data       (parallel_data),
    .parallel_data_valid (parallel_data_valid),
    .parity_error        (parity_error),
    .stop_error          (stop_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (parallel_data_valid) begin
      n_valid         = n_valid + 1;
      prev_valid_cyc  = last_valid_cyc;
      prev_valid_data = last_valid_data;
      last_valid_cyc  = cyc;
      last_valid_data = parallel_data;
    end
    if (parity_error) begin
      n_perr        = n_perr + 1;
      last_perr_cyc = cyc;
    end
    if (stop_error) begin
      n_serr        = n_serr + 1;
      last_serr_cyc = cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    base_v  = n_valid;
    base_pe = n_perr;
    base_se = n_serr;
  endtask

  task automatic drive_bit(input logic b, input int p);
    rx_in = b;
    repeat (p) @(negedge clk);
  endtask

  // Called on a negedge; start_edge is the posedge that first sees the start bit
  task automatic send_frame(input logic [7:0] data, input int p, input logic par_en,
                            input logic par_bit, input logic stop_bit, output int start_edge);
    start_edge = cyc + 1;
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(data[i], p);
    if (par_en) drive_bit(par_bit, p);
    drive_bit(stop_bit, p);
    rx_in = 1'b1;
  endtask

  task automatic expect_good(input string tag, input int start_edge, input int lat,
                             input logic [7:0] data);
    repeat (4) @(negedge clk);
    check_val({tag, "_valid_cnt"}, n_valid - base_v, 1);
    check_val({tag, "_latency"}, last_valid_cyc - start_edge, lat);
    check_val({tag, "_data"}, parallel_data, data);
    check_val({tag, "_no_err"}, (n_perr - base_pe) + (n_serr - base_se), 0);
  endtask

  task automatic expect_quiet(input string tag, input logic [7:0] data);
    check_val({tag, "_valid_cnt"}, n_valid - base_v, 0);
    check_val({tag, "_perr_cnt"}, n_perr - base_pe, 0);
    check_val({tag, "_serr_cnt"}, n_serr - base_se, 0);
    check_val({tag, "_data_hold"}, parallel_data, data);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b1; rx_in = 1'b1;
    prescale = 6'd8; parity_enable = 1'b0; parity_type = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_data", parallel_data, 0);
    check_val("rst_valid", parallel_data_valid, 0);
    check_val("rst_perr", parity_error, 0);
    check_val("rst_serr", stop_error, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // P=8, no parity, 0xA5
    snap(); send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, st);
    expect_good("t1", st, 80, 8'hA5);

    // P=16, even parity: correct then wrong parity bit
    prescale = 6'd16; parity_enable = 1'b1; parity_type = 1'b0;
    snap(); send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, st);
    expect_good("t2_ok", st, 176, 8'h3C);
    snap(); send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, st);
    repeat (4) @(negedge clk);
    check_val("t2_perr_cnt", n_perr - base_pe, 1);
    check_val("t2_perr_lat", last_perr_cyc - st, 176);
    check_val("t2_no_valid", n_valid - base_v, 0);
    check_val("t2_no_serr", n_serr - base_se, 0);
    check_val("t2_data_hold", parallel_data, 8'h3C);

    // P=8, bad stop bit, then a good frame
    prescale = 6'd8; parity_enable = 1'b0;
    snap(); send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, st);
    repeat (4) @(negedge clk);
    check_val("t3_serr_cnt", n_serr - base_se, 1);
    check_val("t3_serr_lat", last_serr_cyc - st, 80);
    check_val("t3_no_valid", n_valid - base_v, 0);
    check_val("t3_no_perr", n_perr - base_pe, 0);
    snap(); send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1, st);
    expect_good("t3_ok", st, 80, 8'h0F);

    // Start-bit glitch: two low cycles only
    snap();
    rx_in = 1'b0; repeat (2) @(negedge clk);
    rx_in = 1'b1; repeat (30) @(negedge clk);
    expect_quiet("t4_glitch", 8'h0F);
    snap(); send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, st);
    expect_good("t4_recover", st, 80, 8'hC3);

    // P=32, odd parity; second run changes prescale mid-frame
    prescale = 6'd32; parity_enable = 1'b1; parity_type = 1'b1;
    snap(); send_frame(8'h81, 32, 1'b1, 1'b1, 1'b1, st);
    expect_good("t5_a", st, 352, 8'h81);
    parallel_data_hold_for_t5: begin
      snap();
      fork
        send_frame(8'h7E, 32, 1'b1, 1'b1, 1'b1, st);
        begin repeat (50) @(negedge clk); prescale = 6'd8; end
      join
      expect_good("t5_b", st, 352, 8'h7E);
    end

    // Illegal prescale falls back to 8
    prescale = 6'd12; parity_enable = 1'b0; parity_type = 1'b0;
    snap(); send_frame(8'h3A, 8, 1'b0, 1'b0, 1'b1, st);
    expect_good("t_illegal_ps", st, 80, 8'h3A);

    // Receiver disabled: frame ignored, data held
    prescale = 6'd8; enable = 1'b0;
    snap(); send_frame(8'h99, 8, 1'b0, 1'b0, 1'b1, st);
    repeat (4) @(negedge clk);
    expect_quiet("t_disabled", 8'h3A);
    enable = 1'b1;
    repeat (2) @(negedge clk);

    // Back-to-back frames with no idle gap
    snap();
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, st1);
    send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1, st2);
    repeat (4) @(negedge clk);
    check_val("t6_valid_cnt", n_valid - base_v, 2);
    check_val("t6_first_lat", prev_valid_cyc - st1, 80);
    check_val("t6_spacing", last_valid_cyc - prev_valid_cyc, 80);
    check_val("t6_first_data", prev_valid_data, 8'h12);
    check_val("t6_second_data", last_valid_data, 8'h34);

    // Third frame aborted by asynchronous reset
    snap();
    drive_bit(1'b0, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b1, 8);
    #2 reset_n = 1'b0;
    #1;
    check_val("t6_rst_data", parallel_data, 0);
    check_val("t6_rst_valid", parallel_data_valid, 0);
    check_val("t6_rst_perr", parity_error, 0);
    check_val("t6_rst_serr", stop_error, 0);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    expect_quiet("t6_after_rst", 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
